// File: rtl/axis_seq_gen_pkg.sv
// Shared encodings for the axis_seq_gen packetised sequence source:
// sequence modes and control FSM states.
package axis_seq_gen_pkg;

    typedef enum logic [1:0] {
        MODE_GEO   = 2'b00,
        MODE_CNT   = 2'b01,
        MODE_LFSR  = 2'b10,
        MODE_CONST = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD   = 2'b01,
        ST_STREAM = 2'b10
    } state_e;

endpackage : axis_seq_gen_pkg

// File: rtl/axis_seq_gen_next.sv
// Combinational next-value unit: maps (mode, current value) to the following
// sequence value; all arithmetic wraps modulo 2^DATA_SIZE.
module axis_seq_gen_next
    import axis_seq_gen_pkg::*;
#(
    parameter int          DATA_SIZE = 32,
    parameter int          MULT      = 3,
    parameter int          STEP      = 1,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
    input  mode_e                mode,
    input  logic [DATA_SIZE-1:0] cur,
    output logic [DATA_SIZE-1:0] nxt
);

    localparam logic [DATA_SIZE-1:0] TAPS   = DATA_SIZE'(LFSR_TAPS);
    localparam logic [DATA_SIZE-1:0] MULT_V = DATA_SIZE'(MULT);
    localparam logic [DATA_SIZE-1:0] STEP_V = DATA_SIZE'(STEP);

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        nxt = cur;
        case (mode)
            MODE_GEO:   nxt = cur * MULT_V;
            MODE_CNT:   nxt = cur + STEP_V;
            // Galois form: shift right, fold the taps in when a 1 falls out.
            MODE_LFSR:  nxt = (cur >> 1) ^ (cur[0] ? TAPS : '0);
            MODE_CONST: nxt = cur;
            default:    nxt = cur;
        endcase
    end

endmodule : axis_seq_gen_next

// File: rtl/axis_seq_gen.sv
// AXI4-Stream master emitting packetised numeric sequences (geometric, counter,
// LFSR, constant). Optional macro AXIS_SEQ_GEN_PKT_CNT_EN adds a pkt_count output.
module axis_seq_gen
    import axis_seq_gen_pkg::*;
#(
    parameter int          DATA_SIZE = 32,
    parameter int          LEN_W     = 8,
    parameter int          MULT      = 3,
    parameter int          STEP      = 1,
    parameter logic [31:0] LFSR_TAPS = 32'h8020_0003
) (
    input  logic                   m00_axis_aclk,
    input  logic                   m00_axis_areset,
    input  logic                   m00_axis_enable,
    input  logic [1:0]             cfg_mode,
    input  logic [DATA_SIZE-1:0]   cfg_seed,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   m00_axis_tready,
    output logic [DATA_SIZE-1:0]   m00_axis_tdata,
    output logic [DATA_SIZE/8-1:0] m00_axis_tstrb,
    output logic                   m00_axis_tvalid,
    output logic                   m00_axis_tlast,
    output logic                   busy
`ifdef AXIS_SEQ_GEN_PKT_CNT_EN
    ,
    output logic [31:0]            pkt_count
`endif
);

    state_e               state_q, state_d;
    mode_e                mode_q;
    logic [LEN_W-1:0]     len_q;
    logic [LEN_W-1:0]     beat_q;
    logic [DATA_SIZE-1:0] data_q;
    logic [DATA_SIZE-1:0] data_nxt;
    logic [DATA_SIZE-1:0] seed_eff;
    logic [LEN_W-1:0]     len_eff;
    logic                 streaming;
    logic                 last_beat;
    logic                 xfer;

    assign streaming = (state_q == ST_STREAM);
    assign last_beat = (beat_q == len_q - LEN_W'(1));
    assign xfer      = streaming && m00_axis_tready;

    // An all-zero LFSR state never leaves zero, so start such packets from 1.
    assign seed_eff = (mode_e'(cfg_mode) == MODE_LFSR && cfg_seed == '0)
                      ? DATA_SIZE'(1) : cfg_seed;
    assign len_eff  = (cfg_len == '0) ? LEN_W'(1) : cfg_len;

    axis_seq_gen_next #(
        .DATA_SIZE (DATA_SIZE),
        .MULT      (MULT),
        .STEP      (STEP),
        .LFSR_TAPS (LFSR_TAPS)
    ) u_next (
        .mode (mode_q),
        .cur  (data_q),
        .nxt  (data_nxt)
    );

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (m00_axis_enable) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (xfer && last_beat) state_d = m00_axis_enable ? ST_LOAD : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Shadow configuration and the beat datapath; config is only sampled in LOAD.
    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            mode_q <= MODE_GEO;
            len_q  <= LEN_W'(1);
            beat_q <= '0;
            data_q <= '0;
        end else begin
            if (state_q == ST_LOAD) begin
                mode_q <= mode_e'(cfg_mode);
                len_q  <= len_eff;
                beat_q <= '0;
                data_q <= seed_eff;
            end else if (xfer && !last_beat) begin
                beat_q <= beat_q + LEN_W'(1);
                data_q <= data_nxt;
            end
        end
    end

`ifdef AXIS_SEQ_GEN_PKT_CNT_EN
    logic [31:0] pkt_count_q;

    always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
        if (m00_axis_areset) begin
            pkt_count_q <= '0;
        end else if (xfer && last_beat) begin
            pkt_count_q <= pkt_count_q + 32'd1;
        end
    end

    assign pkt_count = pkt_count_q;
`endif

    // Outputs decode from registered state, so an async reset clears them at once.
    assign m00_axis_tdata  = data_q;
    assign m00_axis_tvalid = streaming;
    assign m00_axis_tlast  = streaming && last_beat;
    assign m00_axis_tstrb  = {(DATA_SIZE/8){streaming}};
    assign busy            = streaming;

endmodule : axis_seq_gen

// File: doc/axis_seq_gen.md
Name: axis_seq_gen

Overview:
- Parametrised AXI4-Stream master that emits packetised numeric sequences.
- Successor to the single-mode power-of-3 source; adds selectable sequence mode, programmable seed and packet length, real tlast framing and AXI-compliant back-pressure.
- Sits at the head of lab datapaths as a stimulus source feeding downstream stream consumers.

Parameters:
- DATA_SIZE, 32, tdata width in bits (multiple of 8, >= 8).
- LEN_W, 8, width of the packet-length input.
- MULT, 3, multiplier for geometric mode.
- STEP, 1, increment for counter mode.
- LFSR_TAPS, 32'h8020_0003, Galois LFSR feedback mask (low DATA_SIZE bits used).

Ports:
- m00_axis_aclk  in  1  clock.
- m00_axis_areset  in  1  reset; one clock; reset is asynchronous and active-high.
- m00_axis_enable  in  1  run request.
- cfg_mode  in  2  00 geometric, 01 counter, 10 LFSR, 11 constant.
- cfg_seed  in  DATA_SIZE  first value of every packet.
- cfg_len  in  LEN_W  beats per packet; 0 is treated as 1.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tdata  out  DATA_SIZE  sequence value.
- m00_axis_tstrb  out  DATA_SIZE/8  byte strobes.
- m00_axis_tvalid  out  1  beat valid.
- m00_axis_tlast  out  1  last beat of packet.
- busy  out  1  packet in progress.

Behaviour:
- Reset (async assert, sync release): tdata=0, tstrb=0, tvalid=0, tlast=0, busy=0, state IDLE, beat counter 0.
- FSM: IDLE, LOAD, STREAM.
  - IDLE: enable=1 -> LOAD next cycle.
  - LOAD (one cycle, tvalid=0): latch cfg_mode, cfg_seed and cfg_len into shadow registers; tdata <= seed; beat counter <= 0; -> STREAM.
  - STREAM: tvalid=1, tstrb all ones, busy=1.
- Config inputs are ignored outside LOAD. Changes take effect only at the next packet.
- Handshake: a beat transfers when tvalid && tready.
  - While tvalid=1 and tready=0, tdata, tlast and tstrb hold stable.
  - tvalid never drops before the handshake.
- On each transfer (not last beat): tdata <= next(tdata); counter increments.
  - Geometric: tdata*MULT.
  - Counter: tdata+STEP.
  - LFSR: Galois shift right; XOR LFSR_TAPS when the shifted-out bit is 1.
  - Constant: unchanged.
  - All arithmetic is truncated modulo 2^DATA_SIZE; overflow wraps silently.
- tlast=1 exactly on beat index len_eff-1, where len_eff = max(cfg_len,1). For len_eff=1 the first beat carries tlast.
- On the tlast transfer:
  - enable=1 -> LOAD (one idle bubble between packets).
  - enable=0 -> IDLE; tvalid and tlast drop the next cycle; busy=0.
- enable deasserted mid-packet: the packet still completes; no truncation.
- LFSR seed 0 (lock-up): the seed is forced to 1 at LOAD.
- Latency: first tvalid two cycles after enable is sampled high in IDLE.
- Reset mid-packet clears all outputs immediately; the partial packet is abandoned.

Optional Feature:
- Macro AXIS_SEQ_GEN_PKT_CNT_EN.
- Defined: adds output pkt_count [31:0], reset 0, incremented on each tlast transfer, wraps at 2^32.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package axis_seq_gen_pkg: mode encodings (MODE_GEO, MODE_CNT, MODE_LFSR, MODE_CONST), state encodings (ST_IDLE, ST_LOAD, ST_STREAM).
- Sub-module axis_seq_gen_next: purely combinational next-value unit (mode, current value -> next value), parametrised by DATA_SIZE, MULT, STEP and LFSR_TAPS; unit-testable alone.

Test Plan:
- Geometric, seed 1, len 4, tready=1: tdata 1,3,9,27; tlast on 27; enable low -> tvalid=0 afterwards.
- Counter, seed 0xFFFF_FFFE, STEP 1, len 3: tdata FFFF_FFFE, FFFF_FFFF, 0000_0000 (wrap); tlast on third beat.
- Back-pressure: tready toggles 1,0,0,1 during geometric run -> tdata and tlast held through stall cycles; no value skipped or duplicated.
- len 0 and len 1: both give single-beat packets with tlast=1; with enable held, LOAD bubble between beats (tvalid pattern 1,0,1,0...).
- cfg_seed changed mid-packet and enable dropped mid-packet: current packet keeps old seed and completes; next packet starts from the new seed.
- LFSR with seed 0 -> first beat 1; async reset asserted mid-packet -> all outputs 0 without waiting for a clock edge.
